mf_sym_fifo: RTL and testbench

Symbol-rate capture stage directly downstream of the PCMFM matched filter, feeding the trellis detector.
- Delays the symEn strobe by the matched filter's fixed pipeline latency, so each filtered I/Q symbol is captured exactly once.
- Buffers captured symbols in a small FIFO with a valid/ready handshake to the trellis.
- Decouples trellis stalls from the free-running symbol clock and flags any lost symbols.

---
 rtl/mf_sym_fifo_pkg.sv | 15 +
 rtl/mf_sym_fifo_sync_fifo_reg.sv | 78 +++++++
 rtl/mf_sym_fifo.sv | 90 +++++++++
 tb/tb_mf_sym_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mf_sym_fifo_pkg.sv
// Shared trellis types: symbol width and the packed {i,q} symbol carried
// between the matched filter, the capture FIFO and the trellis detector.
// No logic; types and constants only.
package mf_sym_fifo_pkg;

  localparam int SYM_W = 18;

  typedef struct packed {
    logic [SYM_W-1:0] i;
    logic [SYM_W-1:0] q;
  } sym_t;

  localparam int SYM_BITS = $bits(sym_t);

endpackage

// File: rtl/mf_sym_fifo_sync_fifo_reg.sv
// Generic register-array FIFO with occupancy count and a look-ahead head port.
// Latency: a write is visible on head_nxt_o in the same cycle it becomes the head.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module sync_fifo_reg #(
  parameter int WIDTH = 36,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_nxt_o,
  output logic             nxt_vld_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_acc;
  logic             pop_acc;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // Accept/advance decisions, next pointers/level, and the entry that will be head after this edge.
  always_comb begin
    pop_acc  = pop_i & ~empty_o & ~clr_i;
    push_acc = push_i & (~full_o | pop_acc) & ~clr_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
    // A write landing on the slot that becomes head must bypass the array.
    head_nxt_o = (push_acc && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
    nxt_vld_o  = (level_d != '0);
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/mf_sym_fifo.sv
// Symbol capture after the matched filter: aligns symEn to filter latency and buffers symbols for the trellis.
// Latency: MF_LATENCY clocks symEn->capture, then 1 clock capture->valid (no fall-through).
// Backpressure: valid/ready to the trellis; captures while full are dropped and flagged on sticky ovf.
module mf_sym_fifo
  import mf_sym_fifo_pkg::*;
#(
  parameter int MF_LATENCY = 6,
  parameter int AW         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             symEn,
  input  logic             flush,
  input  logic [SYM_W-1:0] iIn,
  input  logic [SYM_W-1:0] qIn,
  input  logic             ready,
  input  logic             ovfClr,
  output logic             valid,
  output logic [SYM_W-1:0] iOut,
  output logic [SYM_W-1:0] qOut,
  output logic [AW:0]      level,
  output logic             ovf
);

  logic [MF_LATENCY-1:0] dly_q, dly_d;
  logic                  cap;
  logic                  pop;
  logic                  drop;
  logic                  ovf_q, ovf_d;
  sym_t                  din;
  sym_t                  head_nxt;
  sym_t                  out_q, out_d;
  logic                  nxt_vld;
  logic                  full;
  logic                  empty;

  assign cap      = dly_q[MF_LATENCY-1];
  assign din.i    = iIn;
  assign din.q    = qIn;
  assign valid    = ~empty;
  assign pop      = valid & ready;
  assign drop     = cap & full & ~pop & ~flush;
  assign iOut     = out_q.i;
  assign qOut     = out_q.q;
  assign ovf      = ovf_q;

  sync_fifo_reg #(
    .WIDTH (SYM_BITS),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (flush),
    .push_i     (cap),
    .pop_i      (pop),
    .din_i      (din),
    .head_nxt_o (head_nxt),
    .nxt_vld_o  (nxt_vld),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Next state of the symEn delay line, the output register and the sticky overflow flag.
  always_comb begin
    dly_d = flush ? '0 : ((dly_q << 1) | MF_LATENCY'(symEn));
    // Output follows the head whenever one will exist; otherwise it keeps the last popped symbol.
    out_d = out_q;
    if (!flush && nxt_vld) out_d = head_nxt;
    // A drop outranks a simultaneous clear so no loss goes unreported.
    ovf_d = ovf_q;
    if (flush)       ovf_d = 1'b0;
    else if (drop)   ovf_d = 1'b1;
    else if (ovfClr) ovf_d = 1'b0;
  end

  // Delay line, output register and overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mf_sym_fifo.sv
module tb_mf_sym_fifo;
  import mf_sym_fifo_pkg::*;

  localparam int LAT = 6;
  localparam int AW  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             symEn;
  logic             flush;
  logic [SYM_W-1:0] iIn;
  logic [SYM_W-1:0] qIn;
  logic             ready;
  logic             ovfClr;
  logic             valid;
  logic [SYM_W-1:0] iOut;
  logic [SYM_W-1:0] qOut;
  logic [AW:0]      level;
  logic             ovf;

  mf_sym_fifo #(.MF_LATENCY(LAT), .AW(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .symEn  (symEn),
    .flush  (flush),
    .iIn    (iIn),
    .qIn    (qIn),
    .ready  (ready),
    .ovfClr (ovfClr),
    .valid  (valid),
    .iOut   (iOut),
    .qOut   (qOut),
    .level  (level),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic [35:0] sb[$];
  logic [35:0] data_at[int];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] qpat(input logic [17:0] i);
    return i ^ 18'h2AAAA;
  endfunction

  // Advance one clock; inputs for the new cycle are driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    symEn = 1'b0;
    if (data_at.exists(cyc)) begin
      {iIn, qIn} = data_at[cyc];
      data_at.delete(cyc);
    end else begin
      iIn = '1;
      qIn = '1;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Pulse symEn this cycle; the filter output for it appears LAT cycles later.
  task automatic send(input logic [17:0] i, input bit keep);
    symEn = 1'b1;
    data_at[cyc + LAT] = {i, qpat(i)};
    if (keep) sb.push_back({i, qpat(i)});
  endtask

  task automatic fill(input int n, input int base);
    for (int j = 1; j <= n; j++) begin
      send(18'(base + j), 1'b1);
      steps(4);
    end
  endtask

  task automatic wait_level(input logic [AW:0] tgt, input string tag);
    int k = 0;
    while (level !== tgt && k < 200) begin
      step();
      k++;
    end
    chk(tag, 64'(level), 64'(tgt));
  endtask

  task automatic drain(input string tag);
    ready = 1'b1;
    wait_level('0, tag);
    ready = 1'b0;
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every accepted head symbol is compared against the scoreboard.
  always @(negedge clk) begin
    if (reset && valid && ready && !flush) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) chk("head_sym", 64'({iOut, qOut}), 64'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; symEn = 1'b0; flush = 1'b0; ready = 1'b0; ovfClr = 1'b0;
    iIn = '1; qIn = '1;
    steps(3);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);
    chk("rst_iout",  64'(iOut),  64'd0);
    chk("rst_qout",  64'(qOut),  64'd0);
    reset = 1'b1;
    steps(2);

    // Latency alignment
    ready = 1'b1;
    send(18'h00123, 1'b1);
    steps(LAT);
    chk("lat_early_valid", 64'(valid), 64'd0);
    step();
    chk("lat_valid", 64'(valid), 64'd1);
    chk("lat_iout",  64'(iOut),  64'h00123);
    chk("lat_qout",  64'(qOut),  64'(qpat(18'h00123)));
    step();
    chk("lat_level0", 64'(level), 64'd0);
    ready = 1'b0;

    // Fill and overflow: 9th symbol dropped
    for (int j = 1; j <= 9; j++) begin
      send(18'(j), j <= 8);
      if (j < 9) steps(4);
    end
    steps(LAT);
    chk("fill_level8", 64'(level), 64'd8);
    chk("fill_ovf_pre", 64'(ovf), 64'd0);
    step();
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_level8", 64'(level), 64'd8);
    drain("drain_fill");
    chk("ovf_sticky", 64'(ovf), 64'd1);
    ovfClr = 1'b1;
    step();
    ovfClr = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);

    // Full with simultaneous push and pop
    fill(8, 16);
    wait_level(4'd8, "pp_full");
    send(18'h19, 1'b1);
    steps(LAT);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("pp_level8", 64'(level), 64'd8);
    chk("pp_ovf0",   64'(ovf),   64'd0);
    drain("drain_pp");

    // ovfClr colliding with a drop
    fill(8, 32);
    wait_level(4'd8, "col_full");
    send(18'h5A, 1'b0);
    steps(LAT + 1);
    chk("col_ovf_set", 64'(ovf), 64'd1);
    send(18'h5B, 1'b0);
    steps(LAT);
    ovfClr = 1'b1;
    step();
    chk("col_set_wins", 64'(ovf), 64'd1);
    step();
    ovfClr = 1'b0;
    chk("col_clr_alone", 64'(ovf), 64'd0);
    drain("drain_col");

    // Flush mid-stream with coincident cap and pop
    fill(8, 48);
    wait_level(4'd8, "fl_full");
    send(18'h3F, 1'b0);
    steps(LAT + 1);
    chk("fl_ovf_pre", 64'(ovf), 64'd1);
    ready = 1'b1;
    steps(3);
    ready = 1'b0;
    chk("fl_level5", 64'(level), 64'd5);
    send(18'h66, 1'b0);
    steps(3);
    send(18'h67, 1'b0);
    steps(3);
    flush = 1'b1;
    ready = 1'b1;
    sb.delete();
    step();
    flush = 1'b0;
    chk("fl_level0", 64'(level), 64'd0);
    chk("fl_valid0", 64'(valid), 64'd0);
    chk("fl_ovf0",   64'(ovf),   64'd0);
    steps(8);
    chk("fl_no_cap_level", 64'(level), 64'd0);
    chk("fl_no_cap_valid", 64'(valid), 64'd0);
    ready = 1'b0;

    // Asynchronous reset mid-operation
    fill(3, 64);
    wait_level(4'd3, "ar_level3");
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid0", 64'(valid), 64'd0);
    chk("ar_level0", 64'(level), 64'd0);
    chk("ar_ovf0",   64'(ovf),   64'd0);
    chk("ar_iout0",  64'(iOut),  64'd0);
    sb.delete();
    steps(2);
    reset = 1'b1;
    send(18'h155, 1'b1);
    steps(LAT);
    chk("ar_early_valid", 64'(valid), 64'd0);
    step();
    chk("ar_valid", 64'(valid), 64'd1);
    chk("ar_iout",  64'(iOut),  64'h155);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("ar_level_end", 64'(level), 64'd0);
    chk("ar_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
